// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle between a raster source and sobel_window_gen.
// The pixel source drives the pixel side; the window generator drives the
// window side that feeds the PE chains.
interface sobel_window_gen_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [71:0] win_out;
    logic        compute_valid;
    logic        win_last;
    logic        frame_done;
    logic        sync_err;

    modport master (
        output pix_in, pix_valid, sof,
        input  win_out, compute_valid, win_last, frame_done, sync_err
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output win_out, compute_valid, win_last, frame_done, sync_err
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the Sobel datapath.
// Buffers the two previous rows and emits one registered 3x3 neighbourhood
// per interior pixel, with frame bookkeeping and a sync-error pulse for
// pixels that arrive while no frame is active.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic               clk,
    input  logic               rst,
    sobel_window_gen_if.slave  bus
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   col_r;
    logic [RW-1:0]   row_r;

    // Line buffers: lb_a holds row r-2, lb_b holds row r-1. Never reset;
    // the FILL rows overwrite every entry before a window can use it.
    logic [7:0]      lb_a_r [IMG_WIDTH];
    logic [7:0]      lb_b_r [IMG_WIDTH];

    // 3x3 window shift register, [row][column], column 2 newest.
    logic [7:0]      win_r [3][3];

    logic [71:0]     win_out_r;
    logic            compute_valid_r;
    logic            win_last_r;
    logic            frame_done_r;
    logic            sync_err_r;

    logic            start_s;
    logic            load_s;
    logic [CW-1:0]   addr_s;
    logic            col_end_s;
    logic [7:0]      new_col_s [3];
    logic [71:0]     win_next_s;

    // An sof pixel always becomes (0,0); any other pixel is used only inside a frame.
    assign start_s   = bus.pix_valid & bus.sof;
    assign load_s    = bus.pix_valid & (bus.sof | (state_r != IDLE));
    assign addr_s    = start_s ? {CW{1'b0}} : col_r;
    assign col_end_s = (col_r == COL_LAST);

    // Form the incoming column and the window as it looks after this pixel's shift.
    always_comb begin
        new_col_s[0] = lb_a_r[addr_s];
        new_col_s[1] = lb_b_r[addr_s];
        new_col_s[2] = bus.pix_in;
        win_next_s   = 72'h0;
        for (int i = 0; i < 3; i++) begin
            win_next_s[8*(3*i)   +: 8] = win_r[i][1];
            win_next_s[8*(3*i+1) +: 8] = win_r[i][2];
            win_next_s[8*(3*i+2) +: 8] = new_col_s[i];
        end
    end

    // Line buffer update: the column moves up one row and the new pixel enters below.
    always_ff @(posedge clk) begin
        if (!rst && load_s) begin
            lb_a_r[addr_s] <= lb_b_r[addr_s];
            lb_b_r[addr_s] <= bus.pix_in;
        end
    end

    // Frame FSM with raster counters, window shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            col_r           <= {CW{1'b0}};
            row_r           <= {RW{1'b0}};
            win_out_r       <= 72'h0;
            compute_valid_r <= 1'b0;
            win_last_r      <= 1'b0;
            frame_done_r    <= 1'b0;
            sync_err_r      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= 8'h00;
                end
            end
        end else begin
            // Pulses last one cycle; win_out is zero whenever no window is presented.
            win_out_r       <= 72'h0;
            compute_valid_r <= 1'b0;
            win_last_r      <= 1'b0;
            frame_done_r    <= 1'b0;
            sync_err_r      <= 1'b0;

            if (load_s) begin
                for (int i = 0; i < 3; i++) begin
                    win_r[i][0] <= win_r[i][1];
                    win_r[i][1] <= win_r[i][2];
                    win_r[i][2] <= new_col_s[i];
                end
            end

            if (start_s) begin
                // New frame (also aborts one in progress); this pixel is (0,0).
                state_r <= FILL;
                col_r   <= CW'(1);
                row_r   <= {RW{1'b0}};
            end else if (bus.pix_valid) begin
                case (state_r)
                    IDLE: begin
                        sync_err_r <= 1'b1;
                    end
                    FILL: begin
                        if (col_end_s) begin
                            col_r <= {CW{1'b0}};
                            row_r <= row_r + RW'(1);
                            if (row_r == RW'(1)) begin
                                state_r <= STREAM;
                            end
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                    end
                    STREAM: begin
                        if (col_end_s) begin
                            col_r <= {CW{1'b0}};
                            row_r <= row_r + RW'(1);
                        end else begin
                            col_r <= col_r + CW'(1);
                        end
                        if (col_r >= CW'(2)) begin
                            compute_valid_r <= 1'b1;
                            win_out_r       <= win_next_s;
                        end
                        if (col_end_s && (row_r == ROW_LAST)) begin
                            win_last_r   <= 1'b1;
                            frame_done_r <= 1'b1;
                            state_r      <= IDLE;
                            row_r        <= {RW{1'b0}};
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        col_r   <= {CW{1'b0}};
                        row_r   <= {RW{1'b0}};
                    end
                endcase
            end
        end
    end

    assign bus.win_out       = win_out_r;
    assign bus.compute_valid = compute_valid_r;
    assign bus.win_last      = win_last_r;
    assign bus.frame_done    = frame_done_r;
    assign bus.sync_err      = sync_err_r;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image with pixel = 16*r+c.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic clk;
    logic rst;
    sobel_window_gen_if bus ();

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests_run;
    int          tests_failed;
    int          win_cnt;
    int          fd_cnt;
    logic [71:0] first_win;
    logic [71:0] last_win;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected window centred at (r-1,c-1) for the pixel accepted at (r,c).
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = 72'h0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[8*(3*i+j) +: 8] = 8'(16*(r-2+i) + (c-2+j));
            end
        end
        return w;
    endfunction

    // Drive one cycle of inputs, then check the registered outputs it produces.
    task automatic step(input logic v, input logic s, input logic r, input logic [7:0] p,
                        input logic ecv, input logic [71:0] ew, input logic elast,
                        input logic eerr);
        rst           = r;
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        @(negedge clk);
        if (bus.compute_valid === 1'b1) begin
            win_cnt++;
            if (win_cnt == 1) first_win = bus.win_out;
            last_win = bus.win_out;
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
        chk("compute_valid", 72'(bus.compute_valid), 72'(ecv));
        chk("win_out", bus.win_out, ecv ? ew : 72'h0);
        chk("win_last", 72'(bus.win_last), 72'(elast));
        chk("frame_done", 72'(bus.frame_done), 72'(elast));
        chk("sync_err", 72'(bus.sync_err), 72'(eerr));
    endtask

    // Send the first npix pixels of a frame in raster order, sof on (0,0).
    task automatic frame(input bit gaps, input int npix);
        int r;
        int c;
        for (int k = 0; k < npix; k++) begin
            r = k / W;
            c = k % W;
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 72'h0, 1'b0, 1'b0);
                end
            end
            step(1'b1, (k == 0), 1'b0, 8'(16*r + c),
                 (r >= 2 && c >= 2), exp_win(r, c), (r == H-1 && c == W-1), 1'b0);
        end
    endtask

    task automatic clear_counts();
        win_cnt   = 0;
        fd_cnt    = 0;
        first_win = 72'h0;
        last_win  = 72'h0;
    endtask

    // Scenario sequence.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = 8'h00;
        rst           = 1'b1;
        clear_counts();

        // Reset state.
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 72'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 72'h0, 1'b0, 1'b0);

        // Continuous frame.
        clear_counts();
        frame(1'b0, W*H);
        chk("cont_windows", 72'(win_cnt), 72'd4);
        chk("cont_frame_done", 72'(fd_cnt), 72'd1);
        chk("cont_first_win", first_win, 72'h222120121110020100);
        chk("cont_last_win", last_win, 72'h333231232221131211);

        // Same frame with gaps.
        clear_counts();
        frame(1'b1, W*H);
        chk("gap_windows", 72'(win_cnt), 72'd4);
        chk("gap_first_win", first_win, 72'h222120121110020100);
        chk("gap_last_win", last_win, 72'h333231232221131211);

        // Pixels without sof while idle are dropped.
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'(k), 1'b0, 72'h0, 1'b0, 1'b1);
        end
        chk("drop_windows", 72'(win_cnt), 72'd0);
        frame(1'b0, W*H);
        chk("drop_then_frame_windows", 72'(win_cnt), 72'd4);

        // sof on the 7th pixel restarts the frame.
        clear_counts();
        frame(1'b0, 6);
        chk("abort_windows", 72'(win_cnt), 72'd0);
        frame(1'b0, W*H);
        chk("restart_windows", 72'(win_cnt), 72'd4);
        chk("restart_first_win", first_win, 72'h222120121110020100);

        // Reset in STREAM after the second window.
        clear_counts();
        frame(1'b0, 3*W);
        chk("pre_reset_windows", 72'(win_cnt), 72'd2);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 72'h0, 1'b0, 1'b0);
        for (int c = 0; c < W; c++) begin
            step(1'b1, 1'b0, 1'b0, 8'(16*3 + c), 1'b0, 72'h0, 1'b0, 1'b1);
        end
        chk("post_reset_windows", 72'(win_cnt), 72'd2);
        chk("post_reset_frame_done", 72'(fd_cnt), 72'd0);
        frame(1'b0, W*H);
        chk("reset_then_frame_windows", 72'(win_cnt), 72'd6);

        // Back-to-back frames with no gap cycle.
        clear_counts();
        frame(1'b0, W*H);
        frame(1'b0, W*H);
        chk("b2b_windows", 72'(win_cnt), 72'd8);
        chk("b2b_frame_done", 72'(fd_cnt), 72'd2);
        chk("b2b_last_win", last_win, 72'h333231232221131211);

        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 72'h0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window front end for the Sobel datapath. Accepts one 8-bit pixel per cycle in raster order, buffers the two previous image rows, and emits one 3x3 neighbourhood per interior pixel with a single-cycle `compute_valid` strobe. It drives the `x_in`/`compute_valid` side of the PE chains: it is the transmitter for the PE stage's input handshake.

## Interface
- `IMG_WIDTH`, 640, pixels per row; legal range 3..4096.
- `IMG_HEIGHT`, 480, rows per frame; legal range 3..4096.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pix_in`  in  8  unsigned pixel.
- `pix_valid`  in  1  `pix_in` is accepted this cycle. The block cannot stall; there is no ready signal.
- `sof`  in  1  qualifies the accepted pixel as pixel (0,0) of a new frame. Ignored when `pix_valid`=0.
- `win_out`  out  72  packed window. `win_out[8*(3*i+j) +: 8]` is the pixel at window row i and column j. Row 0 is image row r-2 (top). Column 0 is image column c-2 (left).
- `compute_valid`  out  1  `win_out` is valid this cycle. One-cycle pulse per window.
- `win_last`  out  1  high with `compute_valid` for the final window of a frame.
- `frame_done`  out  1  one-cycle pulse in the same cycle as `win_last`.
- `sync_err`  out  1  one-cycle pulse, one cycle after a pixel was dropped because no frame was active.

## Operation
- The state machine has three states: IDLE, FILL and STREAM. Reset enters IDLE.
- Counters:
  - `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`.
- Line buffers: two buffers, `lb_a` holding row r-2 and `lb_b` holding row r-1, each IMG_WIDTH x 8 bits. On an accepted pixel at column c:
  - New window column = {`lb_a[c]`, `lb_b[c]`, `pix_in`}, top to bottom.
  - The 3x3 shift register shifts left by one column.
  - `lb_a[c]` <= `lb_b[c]` and `lb_b[c]` <= `pix_in`.
  - Line buffer contents are not reset. FILL guarantees they are overwritten before use.
- State transitions:
  - IDLE: `pix_valid`&`sof` loads the pixel as (0,0) and goes to FILL. `pix_valid` without `sof` drops the pixel, pulses `sync_err` and stays in IDLE.
  - FILL (rows 0..1): no windows. Go to STREAM when `row` becomes 2.
  - STREAM: emit a window for each accepted pixel with c>=2. The accepted pixel (IMG_HEIGHT-1, IMG_WIDTH-1) sets `win_last` and `frame_done` on its window and returns to IDLE.
- Boundary cases:
  - Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame; no border padding.
  - `sof` with `pix_valid` in FILL or STREAM aborts the current frame. That pixel becomes (0,0) of a new frame, state goes to FILL, and no window is emitted for it.
  - Back-to-back frames: `sof` in the cycle after the last pixel is handled by the IDLE rule. No gap cycle is required.
  - Gaps: `pix_valid`=0 freezes all counters, buffers and window registers.
- Output values:
  - When `compute_valid`=0, `win_out` is driven to 0 and `win_last`=0.
  - Pixels are unsigned 8-bit and pass through untouched; no arithmetic is performed in this block.

## Timing
- Latency: the window is registered. `compute_valid` rises in the cycle after the pixel at (r>=2, c>=2) is accepted.
- Throughput: one window per cycle sustained when `pix_valid`=1 continuously in STREAM.
- Reset: `rst` sampled high on a rising edge clears all outputs to 0 on that edge, sets state to IDLE and clears `row`/`col` to 0. A pulse in flight is killed by reset.
- `sync_err` is registered: it is high in the cycle after the dropped pixel.
- Data and control are delivered in the same cycle. Downstream PEs latch `win_out` columns while `compute_valid`=1; no other flow control exists.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = 16*r+c.
- Continuous frame with `sof` on (0,0):
  - Exactly 4 `compute_valid` pulses. The first comes 1 cycle after pixel (2,2) is accepted, with `win_out` bytes 0..8 = 0x00,01,02,10,11,12,20,21,22.
  - The 4th window is 0x11..0x33 with `win_last`=`frame_done`=1.
- Same frame with `pix_valid` toggled pseudo-randomly (about 50% duty): the same 4 windows in the same order with identical values. `win_out`=0 between pulses.
- 3 pixels with `pix_valid`=1 and `sof`=0 from IDLE: 3 `sync_err` pulses and no `compute_valid`. A following proper frame yields the 4 correct windows.
- `sof` reasserted on the 7th pixel: the aborted frame yields 0 windows. The restarted frame yields 4 windows keyed to the new (0,0).
- `rst` for 1 cycle while in STREAM after window 2: all outputs are 0 on the next cycle and no further windows appear. A subsequent full frame yields 4 correct windows.
- Two frames back-to-back with no gap cycle: 8 windows total. There are 2 `frame_done` pulses and the second frame's windows are correct.
